// File: rtl/simon_pkg.sv
// Shared definitions for the Simon sequence controller: state encoding,
// GRYB bit positions and the LFSR feedback mask.
package simon_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    ADD      = 4'd1,
    SHOW_ON  = 4'd2,
    SHOW_OFF = 4'd3,
    WAIT_IN  = 4'd4,
    GAP      = 4'd5,
    ECHO     = 4'd6,
    LOSE     = 4'd7,
    WIN      = 4'd8
  } state_t;

  localparam int BIT_G = 3;
  localparam int BIT_R = 2;
  localparam int BIT_Y = 1;
  localparam int BIT_B = 0;

  // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/simon_lfsr.sv
// Free-running 16-bit Galois LFSR; exposes its low OUT_W bits.
module simon_lfsr
  import simon_pkg::*;
#(
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int          OUT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [OUT_W-1:0] value
);

  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (!rst_n) lfsr <= SEED;
    else        lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
  end

  assign value = lfsr[OUT_W-1:0];

endmodule

// File: rtl/simon_seq_ctrl.sv
// Simon game controller: grows a random pattern, plays it on the GRYB lights
// and checks player presses. Define SIMON_ECHO_EN to light each correct press.
module simon_seq_ctrl
  import simon_pkg::*;
#(
  parameter int          MAX_LEN       = 16,
  parameter int          ON_TICKS      = 50_000_000,
  parameter int          OFF_TICKS     = 25_000_000,
  parameter int          TIMEOUT_TICKS = 250_000_000,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] btn_in,
  output logic [3:0] btn_on,
  output logic [5:0] level,
  output logic       busy,
  output logic       game_over,
  output logic       win
);

  localparam int MAX_A = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int MAX_T = (MAX_A > TIMEOUT_TICKS) ? MAX_A : TIMEOUT_TICKS;
  localparam int TW    = (MAX_T > 1) ? $clog2(MAX_T) : 1;
  localparam int AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [TW-1:0] ON_LD   = TW'(ON_TICKS - 1);
  localparam logic [TW-1:0] OFF_LD  = TW'(OFF_TICKS - 1);
  localparam logic [TW-1:0] TO_LD   = TW'(TIMEOUT_TICKS - 1);
  localparam logic [5:0]    MAX_LVL = 6'(MAX_LEN);

  state_t        state, state_nx, dec_state;
  logic [TW-1:0] timer, timer_nx, dec_timer;
  logic [5:0]    idx, idx_nx, dec_idx, level_nx;
  logic          blink, blink_nx;
  logic [1:0]    mem [MAX_LEN];
  logic [1:0]    rnd;
  logic [3:0]    exp_btn;

  simon_lfsr #(.SEED(LFSR_SEED), .OUT_W(2)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .value (rnd)
  );

  assign exp_btn = 4'b0001 << mem[idx[AW-1:0]];

  // Outcome of a correct press: next step, short gap before growing, or win.
  always_comb begin
    dec_state = WAIT_IN;
    dec_timer = TO_LD;
    dec_idx   = idx + 6'd1;
    if (idx == level - 6'd1) begin
      dec_idx   = idx;
      dec_state = (level == MAX_LVL) ? WIN : GAP;
      dec_timer = (level == MAX_LVL) ? ON_LD : OFF_LD;
    end
  end

  always_comb begin
    state_nx  = state;
    timer_nx  = timer;
    level_nx  = level;
    idx_nx    = idx;
    blink_nx  = blink;
    btn_on    = 4'h0;
    busy      = 1'b0;
    game_over = 1'b0;
    win       = 1'b0;
    case (state)
      IDLE: if (start) state_nx = ADD;
      ADD: begin
        busy     = 1'b1;
        level_nx = level + 6'd1;
        idx_nx   = '0;
        timer_nx = ON_LD;
        state_nx = SHOW_ON;
      end
      SHOW_ON: begin
        busy   = 1'b1;
        btn_on = exp_btn;
        if (timer == '0) begin
          state_nx = SHOW_OFF;
          timer_nx = OFF_LD;
        end else timer_nx = timer - TW'(1);
      end
      SHOW_OFF: begin
        busy = 1'b1;
        if (timer == '0) begin
          if (idx + 6'd1 == level) begin
            idx_nx   = '0;
            state_nx = WAIT_IN;
            timer_nx = TO_LD;
          end else begin
            idx_nx   = idx + 6'd1;
            state_nx = SHOW_ON;
            timer_nx = ON_LD;
          end
        end else timer_nx = timer - TW'(1);
      end
      WAIT_IN: begin
        blink_nx = 1'b1;
        // exp_btn is one-hot, so equality also rejects multi-bit presses
        if (btn_in != 4'h0) begin
          if (btn_in == exp_btn) begin
`ifdef SIMON_ECHO_EN
            state_nx = ECHO;
            timer_nx = ON_LD;
`else
            state_nx = dec_state;
            timer_nx = dec_timer;
            idx_nx   = dec_idx;
`endif
          end else state_nx = LOSE;
        end else if (timer == '0) state_nx = LOSE;
        else timer_nx = timer - TW'(1);
      end
`ifdef SIMON_ECHO_EN
      ECHO: begin
        busy     = 1'b1;
        btn_on   = exp_btn;
        blink_nx = 1'b1;
        if (timer == '0) begin
          state_nx = dec_state;
          timer_nx = dec_timer;
          idx_nx   = dec_idx;
        end else timer_nx = timer - TW'(1);
      end
`endif
      GAP: begin
        busy = 1'b1;
        if (timer == '0) state_nx = ADD;
        else             timer_nx = timer - TW'(1);
      end
      LOSE: begin
        btn_on    = 4'hF;
        game_over = 1'b1;
        if (start) begin
          level_nx = '0;
          state_nx = ADD;
        end
      end
      WIN: begin
        win    = 1'b1;
        btn_on = {4{blink}};
        if (timer == '0) begin
          blink_nx = ~blink;
          timer_nx = ON_LD;
        end else timer_nx = timer - TW'(1);
        if (start) begin
          level_nx = '0;
          state_nx = ADD;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      timer <= '0;
      level <= '0;
      idx   <= '0;
      blink <= 1'b0;
    end else begin
      state <= state_nx;
      timer <= timer_nx;
      level <= level_nx;
      idx   <= idx_nx;
      blink <= blink_nx;
    end
  end

  // Pattern memory needs no reset; every slot is written before it is read.
  always_ff @(posedge clk) begin
    if (state == ADD) mem[level[AW-1:0]] <= rnd;
  end

endmodule

// File: tb/tb_simon_seq_ctrl.sv
// Directed bench for simon_seq_ctrl with a queued scoreboard; honours SIMON_ECHO_EN.
module tb_simon_seq_ctrl;
  import simon_pkg::*;

  localparam int ON = 4;
  localparam int OFF = 2;
  localparam int TO = 20;
  localparam int ML = 3;
  localparam int W = 13;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [3:0] btn_in = 4'h0;
  logic [3:0] btn_on;
  logic [5:0] level;
  logic busy, game_over, win;

  always #5 clk = ~clk;

  simon_seq_ctrl #(
    .MAX_LEN(ML), .ON_TICKS(ON), .OFF_TICKS(OFF), .TIMEOUT_TICKS(TO), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .btn_in(btn_in),
    .btn_on(btn_on), .level(level), .busy(busy), .game_over(game_over), .win(win)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // reference LFSR (x^16+x^14+x^13+x^11+1, Galois, shifting right)
  logic [15:0] m_lfsr;
  always @(posedge clk) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  int tag_q[$];
  string name_q[$];
  int tests = 0;
  int fails = 0;
  string cur = "init";

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got btn_on=%h level=%0d busy=%b game_over=%b win=%b, expected btn_on=%h level=%0d busy=%b game_over=%b win=%b",
               nm, cyc, act[12:9], act[8:3], act[2], act[1], act[0],
               exp[12:9], exp[8:3], exp[2], exp[1], exp[0]);
    end
  endtask

  always @(negedge clk) begin
    while (tag_q.size() > 0 && tag_q[0] == cyc) begin
      check(name_q[0], {btn_on, level, busy, game_over, win}, exp_q[0]);
      void'(tag_q.pop_front());
      void'(exp_q.pop_front());
      void'(name_q.pop_front());
    end
  end

  function automatic logic [W-1:0] ov(input logic [3:0] b, input logic [5:0] l,
                                      input logic bz, input logic go, input logic w);
    return {b, l, bz, go, w};
  endfunction

  // driver
  int lvl = 0;
  logic [1:0] mem_m [ML];

  task automatic tick(input bit chk, input logic [W-1:0] e);
    if (chk) begin
      tag_q.push_back(cyc + 1);
      exp_q.push_back(e);
      name_q.push_back(cur);
    end
    @(posedge clk);
    #1;
  endtask

  // Called during the ADD cycle: record the new step and expect the playback.
  task automatic in_add(input bit poke);
    mem_m[lvl] = m_lfsr[1:0];
    lvl++;
    for (int i = 0; i < lvl; i++) begin
      for (int t = 0; t < ON; t++) begin
        if (poke && i == 0 && t == 1) btn_in = 4'hF;
        tick(1, ov(4'b0001 << mem_m[i], 6'(lvl), 1'b1, 1'b0, 1'b0));
        btn_in = 4'h0;
      end
      for (int t = 0; t < OFF; t++) tick(1, ov(4'h0, 6'(lvl), 1'b1, 1'b0, 1'b0));
    end
    tick(1, ov(4'h0, 6'(lvl), 1'b0, 1'b0, 1'b0));
  endtask

  task automatic new_game();
    start = 1'b1;
    tick(0, '0);
    start = 1'b0;
    lvl = 0;
    in_add(1'b0);
  endtask

  task automatic press_ok(input int i, input bit poke_next);
    bit last;
    logic [W-1:0] res;
    last = (i == lvl - 1);
    if (!last)        res = ov(4'h0, 6'(lvl), 1'b0, 1'b0, 1'b0);
    else if (lvl == ML) res = ov(4'hF, 6'(lvl), 1'b0, 1'b0, 1'b1);
    else              res = ov(4'h0, 6'(lvl), 1'b1, 1'b0, 1'b0);
    btn_in = 4'b0001 << mem_m[i];
`ifdef SIMON_ECHO_EN
    tick(1, ov(btn_in, 6'(lvl), 1'b1, 1'b0, 1'b0));
    btn_in = 4'h0;
    for (int t = 1; t < ON; t++) tick(1, ov(4'b0001 << mem_m[i], 6'(lvl), 1'b1, 1'b0, 1'b0));
    tick(1, res);
`else
    tick(1, res);
    btn_in = 4'h0;
`endif
    if (last && lvl < ML) begin
      tick(1, ov(4'h0, 6'(lvl), 1'b1, 1'b0, 1'b0));
      tick(0, '0);
      in_add(poke_next);
    end
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] wc;
    // reset and idle
    cur = "reset";
    rst_n = 1'b0;
    tick(1, ov(4'h0, 6'd0, 1'b0, 1'b0, 1'b0));
    check("reset_state", {9'b0, dut.state}, {9'b0, IDLE});
    rst_n = 1'b1;
    cur = "idle";
    tick(1, ov(4'h0, 6'd0, 1'b0, 1'b0, 1'b0));

    // full winning game
    cur = "win_r1";
    new_game();
    press_ok(0, 1'b0);
    cur = "win_r2";
    press_ok(0, 1'b0);
    press_ok(1, 1'b0);
    cur = "win_r3";
    press_ok(0, 1'b0);
    press_ok(1, 1'b0);
    press_ok(2, 1'b0);
    cur = "win_blink";
    for (int t = 1; t < ON; t++) tick(1, ov(4'hF, 6'd3, 1'b0, 1'b0, 1'b1));
    for (int t = 0; t < ON; t++) tick(1, ov(4'h0, 6'd3, 1'b0, 1'b0, 1'b1));
    for (int t = 0; t < ON; t++) tick(1, ov(4'hF, 6'd3, 1'b0, 1'b0, 1'b1));

    // restart from WIN, start ignored in WAIT_IN, then timeout
    cur = "restart_from_win";
    new_game();
    cur = "start_ignored";
    start = 1'b1;
    tick(1, ov(4'h0, 6'd1, 1'b0, 1'b0, 1'b0));
    start = 1'b0;
    cur = "timeout_wait";
    for (int k = 0; k < TO - 2; k++) tick(1, ov(4'h0, 6'd1, 1'b0, 1'b0, 1'b0));
    cur = "timeout_lose";
    tick(1, ov(4'hF, 6'd1, 1'b0, 1'b1, 1'b0));
    tick(1, ov(4'hF, 6'd1, 1'b0, 1'b1, 1'b0));

    // press on the last timeout cycle, presses during playback ignored, multi-bit press
    cur = "restart_from_lose";
    new_game();
    cur = "press_at_zero";
    for (int k = 0; k < TO - 1; k++) tick(1, ov(4'h0, 6'd1, 1'b0, 1'b0, 1'b0));
    cur = "press_at_zero_ok";
    press_ok(0, 1'b1);
    cur = "multi_bit";
    btn_in = 4'b0011;
    tick(1, ov(4'hF, 6'd2, 1'b0, 1'b1, 1'b0));
    btn_in = 4'h0;
    tick(1, ov(4'hF, 6'd2, 1'b0, 1'b1, 1'b0));

    // wrong button in round 2
    cur = "wrong_r1";
    new_game();
    press_ok(0, 1'b0);
    cur = "wrong_press";
    wc = mem_m[0] + 2'd1;
    btn_in = 4'b0001 << wc;
    tick(1, ov(4'hF, 6'd2, 1'b0, 1'b1, 1'b0));
    btn_in = 4'h0;
    tick(1, ov(4'hF, 6'd2, 1'b0, 1'b1, 1'b0));

    // restart from LOSE, then reset in the middle of SHOW_ON
    cur = "reset_mid_show";
    start = 1'b1;
    tick(0, '0);
    start = 1'b0;
    mem_m[0] = m_lfsr[1:0];
    tick(1, ov(4'b0001 << mem_m[0], 6'd1, 1'b1, 1'b0, 1'b0));
    tick(1, ov(4'b0001 << mem_m[0], 6'd1, 1'b1, 1'b0, 1'b0));
    rst_n = 1'b0;
    tick(1, ov(4'h0, 6'd0, 1'b0, 1'b0, 1'b0));
    check("reset_mid_state", {9'b0, dut.state}, {9'b0, IDLE});
    rst_n = 1'b1;
    tick(1, ov(4'h0, 6'd0, 1'b0, 1'b0, 1'b0));

    tick(0, '0);
    tick(0, '0);
    tests++;
    if (tag_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d expected entries never compared, required 0", tag_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
